// File: rtl/memb_arb_pkg.sv
// Shared definitions for the port-B memory arbiter: state encoding,
// requester ids and default bus widths.
package memb_arb_pkg;

  localparam int unsigned MEMB_ADDR_W = 14;
  localparam int unsigned MEMB_DATA_W = 64;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_LOCK   = 2'd1,
    ST_DRAIN  = 2'd2
  } memb_state_e;

  typedef enum logic {
    SRC_LD  = 1'b0,
    SRC_CPU = 1'b1
  } memb_src_e;

endpackage

// File: rtl/memb_arb_rdpipe.sv
// Read-return tracker: a valid/id shift register, one stage per cycle
// between grant and port-B read data arriving.
module memb_rdpipe
  import memb_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_vld,
  input  memb_src_e push_id,
  output logic      out_vld,
  output memb_src_e out_id,
  output logic      more_pending
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] id_q, id_d;

  // Advance every stage each cycle; stage 0 takes the new read grant.
  always_comb begin
    vld_d = {vld_q[DEPTH-2:0], push_vld};
    id_d  = {id_q[DEPTH-2:0], logic'(push_id)};
  end

  // Pipeline registers; reset discards any reads in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q <= vld_d;
      id_q  <= id_d;
    end
  end

  // The final stage is delivering this cycle; anything earlier is still to come.
  always_comb begin
    out_vld      = vld_q[DEPTH-1];
    out_id       = memb_src_e'(id_q[DEPTH-1]);
    more_pending = |vld_q[DEPTH-2:0];
  end

endmodule

// File: rtl/memb_arb.sv
// Two-requester arbiter (loader, CPU) for a memory port B, with a
// loader lock mode and a drain phase before normal arbitration resumes.
module memb_arb
  import memb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = MEMB_ADDR_W,
  parameter int unsigned DATA_W   = MEMB_DATA_W,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flsh,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_din,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              enb,
  output logic              web,
  output logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] dinb,
  input  logic [DATA_W-1:0] doutb,
  output logic [1:0]        lock_st
);

  memb_state_e       state_q, state_d;
  logic              favour_ld_q, favour_ld_d;
  logic              enb_q, enb_d;
  logic              web_q, web_d;
  logic [ADDR_W-1:0] addrb_q, addrb_d;
  logic [DATA_W-1:0] dinb_q, dinb_d;

  logic              gnt_any;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;
  logic              rd_push;
  memb_src_e         rd_push_id;
  logic              ret_vld;
  memb_src_e         ret_id;
  logic              rd_more;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: lock on flush, drain outstanding reads once flush drops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL: if (flsh) state_d = ST_LOCK;
      ST_LOCK:   if (!flsh) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (flsh)          state_d = ST_LOCK;
        else if (!rd_more) state_d = ST_NORMAL;
      end
      default:   state_d = ST_NORMAL;
    endcase
  end

  // Grants: round-robin in NORMAL, loader-only under flush/LOCK, none in DRAIN.
  always_comb begin
    ld_gnt  = 1'b0;
    cpu_gnt = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        if (flsh) begin
          ld_gnt = ld_req;
        end else if (ld_req && cpu_req) begin
          ld_gnt  = favour_ld_q;
          cpu_gnt = !favour_ld_q;
        end else begin
          ld_gnt  = ld_req;
          cpu_gnt = cpu_req;
        end
      end
      ST_LOCK: ld_gnt = ld_req;
      default: ;
    endcase
  end

  // Round-robin pointer moves only when a contested NORMAL arbitration grants.
  always_comb begin
    favour_ld_d = favour_ld_q;
    if (state_q == ST_NORMAL && !flsh && ld_req && cpu_req) begin
      favour_ld_d = cpu_gnt;
    end
  end

  // Next port-B drive from the granted request; address and data hold when idle.
  always_comb begin
    gnt_any    = ld_gnt | cpu_gnt;
    sel_we     = cpu_gnt ? cpu_we   : ld_we;
    sel_addr   = cpu_gnt ? cpu_addr : ld_addr;
    sel_din    = cpu_gnt ? cpu_din  : ld_din;
    enb_d      = gnt_any;
    web_d      = gnt_any & sel_we;
    addrb_d    = gnt_any ? sel_addr : addrb_q;
    dinb_d     = dinb_q;
    if (gnt_any) begin
      dinb_d = sel_we ? sel_din : '0;
    end
    rd_push    = gnt_any & ~sel_we;
    rd_push_id = cpu_gnt ? SRC_CPU : SRC_LD;
  end

  // Port-B drive registers and arbitration pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      favour_ld_q <= 1'b1;
      enb_q       <= 1'b0;
      web_q       <= 1'b0;
      addrb_q     <= '0;
      dinb_q      <= '0;
    end else begin
      favour_ld_q <= favour_ld_d;
      enb_q       <= enb_d;
      web_q       <= web_d;
      addrb_q     <= addrb_d;
      dinb_q      <= dinb_d;
    end
  end

  memb_rdpipe #(
    .DEPTH(READ_LAT + 1)
  ) u_rdpipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_vld    (rd_push),
    .push_id     (rd_push_id),
    .out_vld     (ret_vld),
    .out_id      (ret_id),
    .more_pending(rd_more)
  );

  // Read returns routed to their requester; data is zero when not valid.
  always_comb begin
    ld_rvalid  = ret_vld && (ret_id == SRC_LD);
    cpu_rvalid = ret_vld && (ret_id == SRC_CPU);
    ld_rdata   = ld_rvalid  ? doutb : '0;
    cpu_rdata  = cpu_rvalid ? doutb : '0;
    enb        = enb_q;
    web        = web_q;
    addrb      = addrb_q;
    dinb       = dinb_q;
    lock_st    = state_q;
  end

endmodule

// File: doc/memb_arb.md
MEMB_ARB -- requirements
Module: memb_arb

Interface
REQ-001 Parameter ADDR_W, 14, memory port-B word address width.
REQ-002 Parameter DATA_W, 64, memory port-B data width.
REQ-003 Parameter READ_LAT, 1, port-B read latency in cycles from enb to valid doutb (legal 1..3).
REQ-004 clk  in  1  system clock; one clock domain.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 flsh  in  1  loader flush/lock request; when high, only the loader is granted.
REQ-007 ld_req, ld_we  in  1 each  loader access request and write enable.
REQ-008 ld_addr  in  ADDR_W; ld_din  in  DATA_W  loader address and write data.
REQ-009 ld_gnt  out  1  loader request accepted this cycle.
REQ-010 ld_rvalid  out  1; ld_rdata  out  DATA_W  loader read return.
REQ-011 cpu_req, cpu_we  in  1 each; cpu_addr  in  ADDR_W; cpu_din  in  DATA_W  CPU-side requester.
REQ-012 cpu_gnt  out  1; cpu_rvalid  out  1; cpu_rdata  out  DATA_W  CPU grant and read return.
REQ-013 enb, web  out  1 each; addrb  out  ADDR_W; dinb  out  DATA_W  registered port-B drive.
REQ-014 doutb  in  DATA_W  port-B read data.
REQ-015 lock_st  out  2  current FSM state (debug).

Function
REQ-016 At most one of ld_gnt/cpu_gnt is high per cycle; a grant is combinational from req inputs and registered state.
REQ-017 FSM states: NORMAL, LOCK, DRAIN.
REQ-018 NORMAL: both requesting -> grant the one not granted last (round-robin pointer, resets to favour loader); single requester -> grant it.
REQ-019 NORMAL -> LOCK when flsh=1 (same-cycle effect: cpu_gnt=0 in that cycle).
REQ-020 LOCK: only loader granted; LOCK -> DRAIN when flsh=0.
REQ-021 DRAIN: no grants until read pipeline empty; then -> NORMAL; flsh=1 in DRAIN -> LOCK.
REQ-022 Grant in cycle k drives enb=1, web=we, addrb, dinb (dinb=0 on reads) in cycle k+1; no grant -> enb=0, web=0, addrb/dinb hold.
REQ-023 Reads tracked in a READ_LAT+1 deep valid/id shift pipeline; requester's rvalid pulses one cycle in cycle k+1+READ_LAT with rdata=doutb.
REQ-024 Writes produce no rvalid; back-to-back grants every cycle allowed; returns stay in grant order.
REQ-025 rdata outputs are zero when the corresponding rvalid=0.
REQ-026 Round-robin pointer updates only on a grant when both requested.

Reset
REQ-027 rst_n low asynchronously forces: state NORMAL, pointer favours loader, read pipeline empty, enb=0, web=0, addrb=0, dinb=0, all rvalid=0, rdata=0.
REQ-028 Reset mid-operation discards in-flight reads; no rvalid after rst_n deasserts for pre-reset grants.
REQ-029 First grant possible in the first cycle after rst_n deasserts.

Structure
REQ-030 Shared package holds state encoding (NORMAL=0, LOCK=1, DRAIN=2) and ADDR_W/DATA_W defaults, shared with the serial driver and mmu top.
REQ-031 One sub-module natural: memb_rdpipe (parameterised valid/id shift register of depth READ_LAT+1).

Verification
REQ-032 Loader-only read addr 0x0010 at cycle 5, READ_LAT=1, doutb=0x0123456789ABCDEF -> enb=1/addrb=0x0010 at cycle 6, ld_rvalid with that data at cycle 7.
REQ-033 Both request every cycle for 6 cycles -> grants alternate ld,cpu,ld,cpu,ld,cpu; returns in order.
REQ-034 flsh high while cpu_req held -> cpu_gnt=0 from flsh cycle; loader writes pass with web=1.
REQ-035 flsh falls with 2 reads outstanding (READ_LAT=2) -> DRAIN, no grants until both rvalid seen, NORMAL next cycle.
REQ-036 rst_n pulsed with a read in flight -> outputs zero immediately; no rvalid afterwards.
